// File: rtl/pixel_write_sink.sv
// rtl/pixel_write_sink.sv - two-client pixel write arbiter with clipping and a FIFO feeding the VGA plot port
module pixel_write_sink #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [8:0] a_x,
    input  logic [8:0] a_y,
    input  logic [2:0] a_color,
    input  logic       a_writeEn,
    output logic       a_ready,
    input  logic [8:0] b_x,
    input  logic [8:0] b_y,
    input  logic [2:0] b_color,
    input  logic       b_writeEn,
    output logic       b_ready,
    input  logic       drain_en,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic [3:0] fifo_count,
    output logic       full,
    output logic       empty,
    output logic [7:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [8:0]    X_LIM    = 9'(SCREEN_W);
    localparam logic [8:0]    Y_LIM    = 9'(SCREEN_H);

    // Entry layout: {x[8:0], y[7:0], colour[2:0]}
    logic [19:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [8:0]    r_vga_x;
    logic [7:0]    r_vga_y;
    logic [2:0]    r_vga_c;
    logic          r_plot;
    logic [7:0]    r_drop;

    logic          w_full;
    logic          w_empty;
    logic          w_acc_a;
    logic          w_acc_b;
    logic          w_acc;
    logic [8:0]    w_sel_x;
    logic [8:0]    w_sel_y;
    logic [2:0]    w_sel_c;
    logic          w_clip;
    logic          w_push;
    logic          w_pop;
    logic [19:0]   w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot
    assign a_ready = !w_full;
    assign b_ready = !w_full && !a_writeEn;

    assign w_acc_a = a_writeEn && a_ready;
    assign w_acc_b = b_writeEn && b_ready;
    assign w_acc   = w_acc_a || w_acc_b;

    assign w_sel_x = w_acc_a ? a_x     : b_x;
    assign w_sel_y = w_acc_a ? a_y     : b_y;
    assign w_sel_c = w_acc_a ? a_color : b_color;

    assign w_clip = (w_sel_x >= X_LIM) || (w_sel_y >= Y_LIM);
    assign w_push = w_acc && !w_clip;
    assign w_pop  = !w_empty && drain_en;
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_sel_x, w_sel_y[7:0], w_sel_c};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_vga_x <= '0;
            r_vga_y <= '0;
            r_vga_c <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_plot <= w_pop;
            if (w_pop) begin
                r_vga_x <= w_head[19:11];
                r_vga_y <= w_head[10:3];
                r_vga_c <= w_head[2:0];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_acc && w_clip && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_c;
    assign vga_plot   = r_plot;
    assign fifo_count = 4'(r_count);
    assign full       = w_full;
    assign empty      = w_empty;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_pixel_write_sink.sv
// tb/tb_pixel_write_sink.sv - vector table, corner sequences and randomized model check of pixel_write_sink
module tb_pixel_write_sink;
    localparam int DEPTH = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [8:0] a_x, a_y, b_x, b_y;
    logic [2:0] a_color, b_color;
    logic       a_writeEn, b_writeEn, drain_en;
    logic       a_ready, b_ready;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic [3:0] fifo_count;
    logic       full, empty;
    logic [7:0] drop_count;

    pixel_write_sink #(.DEPTH(DEPTH), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .a_x(a_x), .a_y(a_y), .a_color(a_color), .a_writeEn(a_writeEn), .a_ready(a_ready),
        .b_x(b_x), .b_y(b_y), .b_color(b_color), .b_writeEn(b_writeEn), .b_ready(b_ready),
        .drain_en(drain_en),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .fifo_count(fifo_count), .full(full), .empty(empty), .drop_count(drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic a_we; int ax; int ay; int ac;
        logic b_we; int bx; int by; int bc;
        logic drain;
        logic ea; logic eb; int ecnt; logic eplot; int evx; int evy; int evc; int edrop;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    pix_t mq[$];
    int   m_vx, m_vy, m_vc, m_drop;
    logic m_plot;
    logic m_acc_a;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_vx = 0; m_vy = 0; m_vc = 0; m_drop = 0; m_plot = 1'b0; m_acc_a = 1'b0;
    endfunction

    function automatic logic model_ra();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic model_rb();
        return (mq.size() < DEPTH) && !a_writeEn;
    endfunction

    // One rising edge of the behavioural model: pop head, then accept/clip/push per arbitration rules
    function automatic void model_step();
        logic aa, ab, pop;
        int x, y, c;
        pix_t e;
        aa = a_writeEn && model_ra();
        ab = b_writeEn && model_rb();
        pop = (mq.size() != 0) && drain_en;
        m_acc_a = aa;
        if (pop) begin
            e = mq.pop_front();
            m_vx = int'(e.x); m_vy = int'(e.y); m_vc = int'(e.c);
            m_plot = 1'b1;
        end else begin
            m_plot = 1'b0;
        end
        if (aa || ab) begin
            x = aa ? int'(a_x) : int'(b_x);
            y = aa ? int'(a_y) : int'(b_y);
            c = aa ? int'(a_color) : int'(b_color);
            if (x >= 320 || y >= 240) begin
                if (m_drop < 255) m_drop++;
            end else begin
                e.x = 9'(x); e.y = 8'(y); e.c = 3'(c);
                mq.push_back(e);
            end
        end
    endfunction

    task automatic set_in(input logic awe, input int ax, input int ay, input int ac,
                          input logic bwe, input int bx, input int by, input int bc,
                          input logic drn);
        a_writeEn = awe; a_x = 9'(ax); a_y = 9'(ay); a_color = 3'(ac);
        b_writeEn = bwe; b_x = 9'(bx); b_y = 9'(by); b_color = 3'(bc);
        drain_en = drn;
    endtask

    task automatic run_cycle();
        #1;
        chk("a_ready", int'(a_ready), int'(model_ra()));
        chk("b_ready", int'(b_ready), int'(model_rb()));
        @(posedge CLOCK_50);
        model_step();
        #1;
        chk("fifo_count", int'(fifo_count), mq.size());
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("vga_plot", int'(vga_plot), int'(m_plot));
        chk("vga_x", int'(vga_x), m_vx);
        chk("vga_y", int'(vga_y), m_vy);
        chk("vga_colour", int'(vga_colour), m_vc);
        chk("drop_count", int'(drop_count), m_drop);
    endtask

    function automatic vec_t mk(logic awe, int ax, int ay, int ac, logic bwe, int bx, int by, int bc,
                                logic drn, logic ea, logic eb, int ecnt, logic eplot,
                                int evx, int evy, int evc, int edrop);
        vec_t v;
        v.a_we = awe; v.ax = ax; v.ay = ay; v.ac = ac;
        v.b_we = bwe; v.bx = bx; v.by = by; v.bc = bc;
        v.drain = drn; v.ea = ea; v.eb = eb; v.ecnt = ecnt; v.eplot = eplot;
        v.evx = evx; v.evy = evy; v.evc = evc; v.edrop = edrop;
        return v;
    endfunction

    task automatic reset_test(input logic during_drain);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(1, 30 + i, 40 + i, i, 0, 0, 0, 0, 0);
            run_cycle();
        end
        set_in(1, 500, 1, 1, 0, 0, 0, 0, 0);
        run_cycle();
        set_in(1, 60, 61, 6, 1, 70, 71, 7, during_drain);
        if (during_drain) begin
            run_cycle();
            run_cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        chk("rst_drop", int'(drop_count), 0);
        @(posedge CLOCK_50);
        #1;
        chk("rst_hold_count", int'(fifo_count), 0);
        chk("rst_hold_plot", int'(vga_plot), 0);
        #3;
        reset = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) run_cycle();
    endtask

    vec_t tbl[10];
    pix_t plots[$];
    pix_t expw[$];
    int   k;

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #1;
        chk("init_plot", int'(vga_plot), 0);
        chk("init_empty", int'(empty), 1);
        chk("init_full", int'(full), 0);
        chk("init_count", int'(fifo_count), 0);
        chk("init_drop", int'(drop_count), 0);
        #21;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // Single write, A-over-B contention, clipping
        tbl[0] = mk(1, 10, 20, 0,   0, 0, 0, 0,     1, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 0,     0, 0, 0, 0,     1, 1, 1, 0, 1, 10, 20, 0, 0);
        tbl[2] = mk(1, 1, 1, 7,     1, 2, 2, 0,     1, 1, 0, 1, 0, 10, 20, 0, 0);
        tbl[3] = mk(0, 0, 0, 0,     1, 2, 2, 0,     1, 1, 1, 1, 1, 1, 1, 7, 0);
        tbl[4] = mk(0, 0, 0, 0,     0, 0, 0, 0,     1, 1, 1, 0, 1, 2, 2, 0, 0);
        tbl[5] = mk(0, 0, 0, 0,     1, 320, 5, 1,   1, 1, 1, 0, 0, 2, 2, 0, 1);
        tbl[6] = mk(0, 0, 0, 0,     1, 5, 240, 2,   1, 1, 1, 0, 0, 2, 2, 0, 2);
        tbl[7] = mk(0, 0, 0, 0,     1, 319, 239, 5, 1, 1, 1, 1, 0, 2, 2, 0, 2);
        tbl[8] = mk(0, 0, 0, 0,     0, 0, 0, 0,     1, 1, 1, 0, 1, 319, 239, 5, 2);
        tbl[9] = mk(0, 0, 0, 0,     0, 0, 0, 0,     1, 1, 1, 0, 0, 319, 239, 5, 2);
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].a_we, tbl[i].ax, tbl[i].ay, tbl[i].ac,
                   tbl[i].b_we, tbl[i].bx, tbl[i].by, tbl[i].bc, tbl[i].drain);
            #1;
            chk($sformatf("v%0d_a_ready", i), int'(a_ready), int'(tbl[i].ea));
            chk($sformatf("v%0d_b_ready", i), int'(b_ready), int'(tbl[i].eb));
            @(posedge CLOCK_50);
            model_step();
            #1;
            chk($sformatf("v%0d_count", i), int'(fifo_count), tbl[i].ecnt);
            chk($sformatf("v%0d_plot", i), int'(vga_plot), int'(tbl[i].eplot));
            chk($sformatf("v%0d_vga_x", i), int'(vga_x), tbl[i].evx);
            chk($sformatf("v%0d_vga_y", i), int'(vga_y), tbl[i].evy);
            chk($sformatf("v%0d_colour", i), int'(vga_colour), tbl[i].evc);
            chk($sformatf("v%0d_drop", i), int'(drop_count), tbl[i].edrop);
        end

        reset_test(1'b0);
        reset_test(1'b1);

        // Back-pressure: fill with drain off, 9th refused, then 8 back-to-back plots
        for (int i = 0; i < 8; i++) begin
            set_in(1, 100 + i, 50 + i, i, 0, 0, 0, 0, 0);
            run_cycle();
        end
        set_in(1, 200, 199, 7, 0, 0, 0, 0, 0);
        run_cycle();
        chk("bp_count", int'(fifo_count), 8);
        chk("bp_full", int'(full), 1);
        chk("bp_a_ready", int'(a_ready), 0);
        drain_en = 1'b1;
        #1;
        chk("bp_ready_on_pop", int'(a_ready), 0);
        run_cycle();
        chk("bp_plot0", int'(vga_plot), 1);
        chk("bp_x0", int'(vga_x), 100);
        chk("bp_full_clear", int'(full), 0);
        a_writeEn = 1'b0;
        for (int i = 1; i < 8; i++) begin
            run_cycle();
            chk($sformatf("bp_plot%0d", i), int'(vga_plot), 1);
            chk($sformatf("bp_x%0d", i), int'(vga_x), 100 + i);
        end
        chk("bp_empty", int'(empty), 1);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) begin
            set_in(1, 321 + (i % 100), i % 300, 0, 0, 0, 0, 0, 1);
            run_cycle();
        end
        chk("drop_sat", int'(drop_count), 255);

        // Wrap-around with drain toggling every 3 cycles
        plots.delete(); expw.delete();
        k = 0;
        for (int cyc = 0; cyc < 300 && plots.size() < 20; cyc++) begin
            set_in(k < 20, k * 13 + 1, k * 7 + 2, k, 0, 0, 0, 0, ((cyc / 3) % 2) == 0);
            run_cycle();
            if (m_acc_a) k++;
            if (vga_plot) plots.push_back({vga_x, vga_y, vga_colour});
        end
        for (int i = 0; i < 20; i++) expw.push_back({9'(i * 13 + 1), 8'(i * 7 + 2), 3'(i)});
        chk("wrap_plot_count", plots.size(), 20);
        for (int i = 0; i < 20 && i < plots.size(); i++)
            chk($sformatf("wrap_pix%0d", i), int'(plots[i]), int'(expw[i]));

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 335), $urandom_range(0, 250), $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 335), $urandom_range(0, 250), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pixel_write_sink.md
Name: pixel_write_sink

Overview:
- Receiving end of the pixel-write interface (x, y, color, writeEn) driven by the cursor-blink and text-glyph drawing blocks.
- Arbitrates two writer clients and buffers accepted writes in a FIFO.
- Clips off-screen coordinates.
- Drains at most one pixel per clock into the VGA adapter's plot port (vga_x, vga_y, vga_colour, vga_plot).

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SCREEN_W, 320, pixel columns; x >= SCREEN_W is clipped.
- SCREEN_H, 240, pixel rows; y >= SCREEN_H is clipped.

Ports:
- CLOCK_50  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- a_x  in  9  client A (text engine) x.
- a_y  in  9  client A y.
- a_color  in  3  client A colour.
- a_writeEn  in  1  client A write request.
- a_ready  out  1  client A write accepted this cycle if a_writeEn.
- b_x  in  9  client B (cursor blink) x.
- b_y  in  9  client B y.
- b_color  in  3  client B colour.
- b_writeEn  in  1  client B write request.
- b_ready  out  1  client B write accepted this cycle if b_writeEn.
- drain_en  in  1  1 = pop enabled; 0 holds FIFO contents (used during screen clear).
- vga_x  out  9  registered pixel x to the VGA adapter.
- vga_y  out  8  registered pixel y to the VGA adapter.
- vga_colour  out  3  registered pixel colour.
- vga_plot  out  1  registered one-cycle plot strobe.
- fifo_count  out  4  current occupancy, 0..DEPTH.
- full  out  1  fifo_count == DEPTH.
- empty  out  1  fifo_count == 0.
- drop_count  out  8  clipped-write counter, saturates at 255.

Behaviour:
- Reset (reset == 0, asynchronous): FIFO flushed, fifo_count = 0, empty = 1, full = 0, vga_plot = 0, vga_x/vga_y/vga_colour = 0, drop_count = 0. Reset mid-drain discards all queued entries; no plot is issued after reset asserts.
- Ready logic (combinational from registered state and requests only):
  - a_ready = !full.
  - b_ready = !full && !a_writeEn. Fixed priority A over B.
  - A pending B write keeps b_writeEn high until b_ready; B's hold is its own responsibility.
- Acceptance: a write is accepted on an edge where writeEn && ready. At most one acceptance per cycle.
- Clipping: an accepted write with x >= SCREEN_W or y >= SCREEN_H completes the handshake but is not pushed. drop_count increments, holding at 255.
- Push stores {x, y[7:0], color}; y is within range after clipping, so truncation is lossless.
- Pop:
  - When !empty && drain_en, the head entry is popped on the edge.
  - vga_x/y/colour are loaded from it and vga_plot = 1 for the following cycle.
  - Otherwise vga_plot = 0 and the vga_x/y/colour hold their last values.
- Latency: a write accepted at edge E into an empty FIFO with drain_en = 1 is popped at edge E+1. vga_plot is high between E+1 and E+2.
- Simultaneous push and pop: fifo_count unchanged. Ordering is strict FIFO. Read/write pointers wrap modulo DEPTH.
- Full: ready is low even if a pop occurs the same cycle (no bypass). Full deasserts the cycle after the pop.
- Empty with a push in the same cycle: no bypass; the new entry is popped the next edge at the earliest.
- drain_en low: FIFO fills to DEPTH, then both ready outputs drop. Contents are preserved and resume draining in order when drain_en returns high.
- Throughput: sustained one pixel per clock with a single active client.

Test Plan:
- Reset check: assert reset with writes pending -> all outputs at reset values, including vga_plot = 0 and empty = 1; no plot after release until a new write.
- Single write: A writes (10, 20, 3'b000) at edge E, drain_en = 1 -> vga_plot high exactly one cycle after E+1 with vga_x = 10, vga_y = 20, vga_colour = 0.
- Contention: A (1,1,7) and B (2,2,0) requested in the same cycle, B held high -> A accepted first, b_ready = 0 that cycle; B accepted the next cycle; plots appear in order A then B.
- Back-pressure: drain_en = 0, A writes 8 consecutive pixels -> fifo_count = 8, full = 1, a_ready = 0; 9th request not accepted. Raise drain_en -> 8 plots on 8 consecutive cycles in push order, then empty = 1.
- Clipping: B writes (320, 5) then (5, 240) then (319, 239) -> drop_count = 2; only (319, 239) plotted. 260 out-of-range writes -> drop_count saturates at 255.
- Wrap-around: 20 writes streamed with drain_en toggling every 3 cycles -> all 20 plotted in order, none lost or duplicated.
